control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/ctrl_pkg.sv | 37 +++
 rtl/alu_decoder.sv | 39 +++
 rtl/control_fsm.sv | 181 ++++++++++++++++++
 tb/tb_control_fsm.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state enum, instruction classes, ALU commands.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  function automatic logic is_arith(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU/flag decode for data-processing states; also suppresses write-back for CMP.
module alu_decoder
  import ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] funct,
  input  logic       reg_w_in,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       reg_w
);

  logic [3:0] cmd;
  logic       s_bit;

  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    reg_w       = reg_w_in;
    if (state == EXECUTER || state == EXECUTEI || state == ALUWB) begin
      case (cmd)
        CMD_ADD:          alu_control = ALU_ADD;
        CMD_SUB, CMD_CMP: alu_control = ALU_SUB;
        CMD_AND:          alu_control = ALU_AND;
        CMD_ORR:          alu_control = ALU_ORR;
        default:          alu_control = ALU_ADD;
      endcase
    end
    if (state == EXECUTER || state == EXECUTEI)
      flag_w = {s_bit, s_bit & is_arith(cmd)};
    // CMP only sets flags; its result is never written back
    if (state == ALUWB && cmd == CMD_CMP)
      reg_w = 1'b0;
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer with registered Moore outputs.
// Define CTRL_FSM_STATE_DBG_EN to expose the current state on state_dbg.
//
// state    | meaning
// FETCH    | read instruction, PC += 4
// DECODE   | read registers, precompute PC + 8
// MEMADR   | compute load/store address
// MEMREAD  | read data memory
// MEMWB    | write loaded data to register file
// MEMWRITE | write data memory
// EXECUTER | ALU op, register operand
// EXECUTEI | ALU op, immediate operand
// ALUWB    | write ALU result to register file
// BRANCH   | compute branch target, load PC
module control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  output logic       pcs,
  output logic       reg_w,
  output logic       mem_w,
  output logic [1:0] flag_w,
  output logic       next_pc,
  output logic       ir_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_control
`ifdef CTRL_FSM_STATE_DBG_EN
  ,
  output logic [3:0] state_dbg
`endif
);

  state_t     state_q, state_d;
  logic       run_q;
  logic [3:0] rd_q, rd_d;

  logic       pcs_q, pcs_d, reg_w_q, mem_w_q, mem_w_d;
  logic       next_pc_q, next_pc_d, ir_write_q, ir_write_d, adr_src_q, adr_src_d;
  logic [1:0] flag_w_q, alu_control_q;
  logic [1:0] alu_src_a_q, alu_src_a_d, alu_src_b_q, alu_src_b_d;
  logic [1:0] result_src_q, result_src_d;
  logic       reg_w_base, reg_w_d;
  logic [1:0] flag_w_d, alu_control_d;

  // run_q holds the first cycle after reset in FETCH so FETCH outputs appear for a full cycle
  always_comb begin
    state_d = FETCH;
    if (run_q) begin
      case (state_q)
        FETCH:  state_d = DECODE;
        DECODE: begin
          case (op)
            OP_DP:   state_d = funct[5] ? EXECUTEI : EXECUTER;
            OP_MEM:  state_d = MEMADR;
            OP_BR:   state_d = BRANCH;
            OP_NOP:  state_d = FETCH;
            default: state_d = FETCH;
          endcase
        end
        MEMADR:             state_d = funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD:            state_d = MEMWB;
        EXECUTER, EXECUTEI: state_d = ALUWB;
        default:            state_d = FETCH;
      endcase
    end
  end

  // rd is captured in DECODE so write-back states never depend on the bus after decode
  assign rd_d = (state_q == DECODE) ? rd : rd_q;

  always_comb begin
    next_pc_d    = 1'b0;
    ir_write_d   = 1'b0;
    adr_src_d    = 1'b0;
    mem_w_d      = 1'b0;
    reg_w_base   = 1'b0;
    alu_src_a_d  = 2'b00;
    alu_src_b_d  = 2'b00;
    result_src_d = 2'b00;
    case (state_d)
      FETCH: begin
        ir_write_d   = 1'b1;
        next_pc_d    = 1'b1;
        alu_src_a_d  = 2'b01;
        alu_src_b_d  = 2'b10;
        result_src_d = 2'b10;
      end
      DECODE: begin
        alu_src_a_d  = 2'b01;
        alu_src_b_d  = 2'b10;
        result_src_d = 2'b10;
      end
      MEMADR:   alu_src_b_d = 2'b01;
      MEMREAD:  adr_src_d   = 1'b1;
      MEMWB: begin
        result_src_d = 2'b01;
        reg_w_base   = 1'b1;
      end
      MEMWRITE: begin
        adr_src_d = 1'b1;
        mem_w_d   = 1'b1;
      end
      EXECUTEI: alu_src_b_d = 2'b01;
      ALUWB:    reg_w_base  = 1'b1;
      BRANCH: begin
        alu_src_b_d  = 2'b01;
        result_src_d = 2'b10;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .state       (state_d),
    .funct       (funct[4:0]),
    .reg_w_in    (reg_w_base),
    .alu_control (alu_control_d),
    .flag_w      (flag_w_d),
    .reg_w       (reg_w_d)
  );

  assign pcs_d = (state_d == BRANCH) | (reg_w_d & (rd_d == 4'hF));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FETCH;
      run_q         <= 1'b0;
      rd_q          <= 4'h0;
      pcs_q         <= 1'b0;
      reg_w_q       <= 1'b0;
      mem_w_q       <= 1'b0;
      flag_w_q      <= 2'b00;
      next_pc_q     <= 1'b0;
      ir_write_q    <= 1'b0;
      adr_src_q     <= 1'b0;
      alu_src_a_q   <= 2'b00;
      alu_src_b_q   <= 2'b00;
      result_src_q  <= 2'b00;
      alu_control_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      run_q         <= 1'b1;
      rd_q          <= rd_d;
      pcs_q         <= pcs_d;
      reg_w_q       <= reg_w_d;
      mem_w_q       <= mem_w_d;
      flag_w_q      <= flag_w_d;
      next_pc_q     <= next_pc_d;
      ir_write_q    <= ir_write_d;
      adr_src_q     <= adr_src_d;
      alu_src_a_q   <= alu_src_a_d;
      alu_src_b_q   <= alu_src_b_d;
      result_src_q  <= result_src_d;
      alu_control_q <= alu_control_d;
    end
  end

  assign pcs         = pcs_q;
  assign reg_w       = reg_w_q;
  assign mem_w       = mem_w_q;
  assign flag_w      = flag_w_q;
  assign next_pc     = next_pc_q;
  assign ir_write    = ir_write_q;
  assign adr_src     = adr_src_q;
  assign alu_src_a   = alu_src_a_q;
  assign alu_src_b   = alu_src_b_q;
  assign result_src  = result_src_q;
  assign alu_control = alu_control_q;

`ifdef CTRL_FSM_STATE_DBG_EN
  assign state_dbg = state_q;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: checks every output each cycle against hand-written vectors.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] op = 2'b11;
  logic [5:0] funct = 6'd0;
  logic [3:0] rd = 4'd0;
  logic       pcs, reg_w, mem_w, next_pc, ir_write, adr_src;
  logic [1:0] flag_w, alu_src_a, alu_src_b, result_src, alu_control;
`ifdef CTRL_FSM_STATE_DBG_EN
  logic [3:0] state_dbg;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  control_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct       (funct),
    .rd          (rd),
    .pcs         (pcs),
    .reg_w       (reg_w),
    .mem_w       (mem_w),
    .flag_w      (flag_w),
    .next_pc     (next_pc),
    .ir_write    (ir_write),
    .adr_src     (adr_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .alu_control (alu_control)
`ifdef CTRL_FSM_STATE_DBG_EN
    ,
    .state_dbg   (state_dbg)
`endif
  );

  always #5 clk = ~clk;

  // {pcs, reg_w, mem_w, flag_w, next_pc, ir_write, adr_src, alu_src_a, alu_src_b, result_src, alu_control}
  logic [15:0] obs;
  assign obs = {pcs, reg_w, mem_w, flag_w, next_pc, ir_write, adr_src,
                alu_src_a, alu_src_b, result_src, alu_control};

  function automatic logic [15:0] mk(input logic p, input logic rw, input logic mw,
                                     input logic [1:0] fw, input logic npc, input logic irw,
                                     input logic adr, input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] res, input logic [1:0] alu);
    return {p, rw, mw, fw, npc, irw, adr, a, b, res, alu};
  endfunction

  task automatic chk(input string tag, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: outputs observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [15:0] exp);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  logic [15:0] z, fet, dec, madr, mrd, mwb, mwr, br;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    z    = 16'h0000;
    fet  = mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00);
    dec  = mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00);
    madr = mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00);
    mrd  = mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    mwb  = mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00);
    mwr  = mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    br   = mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00);

    // reset held across a rising edge
    #12;
    chk("reset_outputs_zero", z);
    @(negedge clk);
    rst = 1'b1;
    cyc("release_fetch", fet);

    // ADD r3 (register operand, no S)
    op = 2'b00; funct = 6'b001000; rd = 4'd3;
    cyc("add_decode", dec);
    cyc("add_executer", z);
    cyc("add_aluwb", mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00));
    cyc("add_fetch", fet);

    // LDR r2
    op = 2'b01; funct = 6'b011001; rd = 4'd2;
    cyc("ldr_decode", dec);
    cyc("ldr_memadr", madr);
    cyc("ldr_memread", mrd);
    cyc("ldr_memwb", mwb);
    cyc("ldr_fetch_c6", fet);

    // STR
    op = 2'b01; funct = 6'b011000; rd = 4'd5;
    cyc("str_decode", dec);
    cyc("str_memadr", madr);
    cyc("str_memwrite", mwr);
    cyc("str_fetch_c5", fet);

    // CMP with S: flags written, no write-back
    op = 2'b00; funct = 6'b010101; rd = 4'd1;
    cyc("cmp_decode", dec);
    cyc("cmp_executer", mk(1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01));
    cyc("cmp_aluwb", mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01));
    cyc("cmp_fetch", fet);

    // SUB immediate with S
    op = 2'b00; funct = 6'b100101; rd = 4'd4;
    cyc("subi_decode", dec);
    cyc("subi_executei", mk(1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b01));
    cyc("subi_aluwb", mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01));
    cyc("subi_fetch", fet);

    // AND with S: logical op sets only flag_w[1]
    op = 2'b00; funct = 6'b000001; rd = 4'd6;
    cyc("and_decode", dec);
    cyc("and_executer", mk(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10));
    cyc("and_aluwb", mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10));
    cyc("and_fetch", fet);

    // ORR immediate, no S
    op = 2'b00; funct = 6'b111000; rd = 4'd7;
    cyc("orri_decode", dec);
    cyc("orri_executei", mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b11));
    cyc("orri_aluwb", mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11));
    cyc("orri_fetch", fet);

    // unlisted cmd 0001 with S decodes as ADD, not arithmetic for flags
    op = 2'b00; funct = 6'b000011; rd = 4'd8;
    cyc("other_decode", dec);
    cyc("other_executer", mk(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00));
    cyc("other_aluwb", mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00));
    cyc("other_fetch", fet);

    // ADD to r15 raises pcs on write-back
    op = 2'b00; funct = 6'b001000; rd = 4'hF;
    cyc("addpc_decode", dec);
    cyc("addpc_executer", z);
    cyc("addpc_aluwb", mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00));
    cyc("addpc_fetch", fet);

    // CMP to r15: masked reg_w keeps pcs low
    op = 2'b00; funct = 6'b010100; rd = 4'hF;
    cyc("cmppc_decode", dec);
    cyc("cmppc_executer", mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01));
    cyc("cmppc_aluwb", mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01));
    cyc("cmppc_fetch", fet);

    // B: three cycles
    op = 2'b10; funct = 6'b000000; rd = 4'd0;
    cyc("b_decode", dec);
    cyc("b_branch", br);
    cyc("b_fetch_c4", fet);

    // op=11: two cycles
    op = 2'b11; funct = 6'b111111; rd = 4'hF;
    cyc("nop_decode", dec);
    cyc("nop_fetch_c3", fet);

    // LDR to r15 via MEMWB raises pcs
    op = 2'b01; funct = 6'b011001; rd = 4'hF;
    cyc("ldrpc_decode", dec);
    cyc("ldrpc_memadr", madr);
    cyc("ldrpc_memread", mrd);
    cyc("ldrpc_memwb", mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00));
    cyc("ldrpc_fetch", fet);

    // LDR abandoned by reset during MEMREAD
    op = 2'b01; funct = 6'b011001; rd = 4'd2;
    cyc("ldrrst_decode", dec);
    cyc("ldrrst_memadr", madr);
    cyc("ldrrst_memread", mrd);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_async_zero", z);
    cyc("rst_held_zero", z);
    @(negedge clk);
    rst = 1'b1;
    op = 2'b11; funct = 6'b000000; rd = 4'd0;
    cyc("rst_resume_fetch", fet);
    cyc("rst_resume_decode", dec);
    cyc("rst_resume_fetch2", fet);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
